eth_rx_frame_queue: RTL and testbench

- Store-and-forward frame buffer directly downstream of the RX FIFO write stage. It is the consumer of the frame_q_write / frame_q_confirm / frame_q_erase / frame_q_din interface, and the producer of frame_q_full.
- Words are written speculatively. Confirm commits the open frame; erase rolls the write pointer back to the last commit.
- Only committed words are presented on an AXI-Stream master towards the host DMA, so no partial or corrupted frame ever leaves the block.

---
 rtl/eth_rx_pkg.sv | 23 ++
 rtl/eth_rx_frame_queue_ram.sv | 46 ++++
 rtl/eth_rx_frame_queue.sv | 189 ++++++++++++++++++
 tb/tb_eth_rx_frame_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// ---------------------------------------------------------------------------
// eth_rx_pkg
// Shared definitions for the RX frame queue: word width, field positions
// inside the 577-bit queue word and the packed view of one queue word.
// ---------------------------------------------------------------------------
package eth_rx_pkg;

   localparam int FRAME_Q_W = 577;
   localparam int DATA_W    = 512;
   localparam int KEEP_W    = 64;

   // Field positions inside frame_q_din
   localparam int DATA_LSB  = 0;
   localparam int KEEP_LSB  = 512;
   localparam int LAST_BIT  = 576;

   typedef struct packed {
      logic              last;
      logic [KEEP_W-1:0] keep;
      logic [DATA_W-1:0] data;
   } frame_word_t;

endpackage

// File: rtl/eth_rx_frame_queue_ram.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_queue_ram
// Simple dual-port storage for the frame queue: one write port, one read
// port with a single cycle of registered read latency. Contents are not
// reset.
// Ports:
//   clk      - clock
//   wr_en    - write wr_data at wr_addr
//   wr_addr  - write address
//   wr_data  - write word
//   rd_en    - capture mem[rd_addr] into rd_data at the next edge
//   rd_addr  - read address
//   rd_data  - registered read word
// ---------------------------------------------------------------------------
module eth_rx_frame_queue_ram
   import eth_rx_pkg::*;
#(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [FRAME_Q_W-1:0] wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [FRAME_Q_W-1:0] rd_data
);

   logic [FRAME_Q_W-1:0] mem_r [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/eth_rx_frame_queue.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_queue
// Store-and-forward frame buffer. Words are written speculatively at wr_ptr;
// confirm moves commit_ptr up to the write pointer, erase rolls wr_ptr back
// to commit_ptr. Only committed words are read from RAM into a 2-entry
// output FIFO that drives an AXI-Stream master.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   frame_q_write         - write frame_q_din at the speculative pointer
//   frame_q_confirm       - commit the open frame (incl. this cycle's word)
//   frame_q_erase         - discard the open frame (wins over write/confirm)
//   frame_q_din           - {last, keep[63:0], data[511:0]}
//   frame_q_full          - no free word (register decode only)
//   m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast - AXI-Stream master
//   dbg_committed_frames  - confirm events
//   dbg_erased_frames     - erase events that discarded words
//   dbg_overflow          - sticky: write attempted while full
//   dbg_level             - committed plus speculative words held
// ---------------------------------------------------------------------------
module eth_rx_frame_queue
   import eth_rx_pkg::*;
#(
   parameter  int DEPTH  = 512,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_q_write,
   input  logic                 frame_q_confirm,
   input  logic                 frame_q_erase,
   input  logic [FRAME_Q_W-1:0] frame_q_din,
   output logic                 frame_q_full,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic [DATA_W-1:0]    m_tdata,
   output logic [KEEP_W-1:0]    m_tkeep,
   output logic                 m_tlast,
   output logic [31:0]          dbg_committed_frames,
   output logic [31:0]          dbg_erased_frames,
   output logic                 dbg_overflow,
   output logic [ADDR_W:0]      dbg_level
);

   localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] PTR_DEPTH = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W:0]      wr_ptr_r, commit_ptr_r, rd_ptr_r;
   logic [ADDR_W:0]      wr_ptr_nx_s, commit_ptr_nx_s;
   logic                 full_s, wr_accept_s, rd_issue_s;
   logic                 inflight_r;
   logic                 push_s, pop_s;
   logic [1:0]           fifo_cnt_r;
   logic [1:0]           out_load_s;
   frame_word_t          fifo_head_r, fifo_tail_r;
   frame_word_t          din_word_s, ram_word_s;
   logic [FRAME_Q_W-1:0] ram_rd_data_s;
   logic [31:0]          committed_r, erased_r;
   logic                 overflow_r;

   assign din_word_s.data = frame_q_din[DATA_LSB +: DATA_W];
   assign din_word_s.keep = frame_q_din[KEEP_LSB +: KEEP_W];
   assign din_word_s.last = frame_q_din[LAST_BIT];
   assign ram_word_s      = ram_rd_data_s;

   // Full is a pure register decode, so upstream can use it the same cycle
   assign full_s = ((wr_ptr_r - rd_ptr_r) == PTR_DEPTH);

   // FIFO occupancy after this cycle's pop plus the read already in flight;
   // counting the pop lets reads issue every cycle under m_tready=1
   assign pop_s      = (fifo_cnt_r != 2'd0) && m_tready;
   assign push_s     = inflight_r;
   assign out_load_s = fifo_cnt_r - {1'b0, pop_s} + {1'b0, inflight_r};
   assign rd_issue_s = (rd_ptr_r != commit_ptr_r) && (out_load_s < 2'd2);

   // Next write/commit pointers; erase wins over write and confirm
   always_comb begin
      wr_accept_s     = frame_q_write && !full_s && !frame_q_erase;
      wr_ptr_nx_s     = wr_ptr_r;
      commit_ptr_nx_s = commit_ptr_r;
      if (frame_q_erase) begin
         wr_ptr_nx_s = commit_ptr_r;
      end else if (wr_accept_s) begin
         wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nx_s = wr_ptr_r;
      end
      // wr_ptr_nx_s already includes a word accepted this cycle
      if (!frame_q_erase && frame_q_confirm) begin
         commit_ptr_nx_s = wr_ptr_nx_s;
      end else begin
         commit_ptr_nx_s = commit_ptr_r;
      end
   end

   // Pointer registers and read-in-flight flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r     <= '0;
         commit_ptr_r <= '0;
         rd_ptr_r     <= '0;
         inflight_r   <= 1'b0;
      end else begin
         wr_ptr_r     <= wr_ptr_nx_s;
         commit_ptr_r <= commit_ptr_nx_s;
         inflight_r   <= rd_issue_s;
         if (rd_issue_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   eth_rx_frame_queue_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_accept_s),
      .wr_addr (wr_ptr_r[ADDR_W-1:0]),
      .wr_data (din_word_s),
      .rd_en   (rd_issue_s),
      .rd_addr (rd_ptr_r[ADDR_W-1:0]),
      .rd_data (ram_rd_data_s)
   );

   // Two-entry output FIFO; head is the word presented on m_*
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_head_r <= '0;
         fifo_tail_r <= '0;
         fifo_cnt_r  <= 2'd0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (fifo_cnt_r == 2'd0) begin
                  fifo_head_r <= ram_word_s;
               end else begin
                  fifo_tail_r <= ram_word_s;
               end
               fifo_cnt_r <= fifo_cnt_r + 2'd1;
            end
            2'b01: begin
               fifo_head_r <= fifo_tail_r;
               fifo_cnt_r  <= fifo_cnt_r - 2'd1;
            end
            2'b11: begin
               if (fifo_cnt_r == 2'd1) begin
                  fifo_head_r <= ram_word_s;
               end else begin
                  fifo_head_r <= fifo_tail_r;
                  fifo_tail_r <= ram_word_s;
               end
            end
            default: begin
               fifo_cnt_r <= fifo_cnt_r;
            end
         endcase
      end
   end

   // Debug counters and sticky overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         committed_r <= 32'd0;
         erased_r    <= 32'd0;
         overflow_r  <= 1'b0;
      end else begin
         if (frame_q_confirm && !frame_q_erase) begin
            committed_r <= committed_r + 32'd1;
         end
         if (frame_q_erase && (wr_ptr_r != commit_ptr_r)) begin
            erased_r <= erased_r + 32'd1;
         end
         if (frame_q_write && full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   assign frame_q_full         = full_s;
   assign m_tvalid             = (fifo_cnt_r != 2'd0);
   assign m_tdata              = fifo_head_r.data;
   assign m_tkeep              = fifo_head_r.keep;
   assign m_tlast              = fifo_head_r.last;
   assign dbg_committed_frames = committed_r;
   assign dbg_erased_frames    = erased_r;
   assign dbg_overflow         = overflow_r;
   assign dbg_level            = wr_ptr_r - rd_ptr_r;

endmodule

// File: tb/tb_eth_rx_frame_queue.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_frame_queue
// Directed bench for eth_rx_frame_queue with DEPTH=8. Inputs change and
// outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_eth_rx_frame_queue;
   import eth_rx_pkg::*;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = $clog2(DEPTH);

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 frame_q_write, frame_q_confirm, frame_q_erase;
   logic [FRAME_Q_W-1:0] frame_q_din;
   logic                 frame_q_full;
   logic                 m_tvalid, m_tready, m_tlast;
   logic [DATA_W-1:0]    m_tdata;
   logic [KEEP_W-1:0]    m_tkeep;
   logic [31:0]          dbg_committed_frames, dbg_erased_frames;
   logic                 dbg_overflow;
   logic [ADDR_W:0]      dbg_level;

   int tests = 0;
   int fails = 0;
   frame_word_t expq[$];

   eth_rx_frame_queue #(.DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .frame_q_write        (frame_q_write),
      .frame_q_confirm      (frame_q_confirm),
      .frame_q_erase        (frame_q_erase),
      .frame_q_din          (frame_q_din),
      .frame_q_full         (frame_q_full),
      .m_tvalid             (m_tvalid),
      .m_tready             (m_tready),
      .m_tdata              (m_tdata),
      .m_tkeep              (m_tkeep),
      .m_tlast              (m_tlast),
      .dbg_committed_frames (dbg_committed_frames),
      .dbg_erased_frames    (dbg_erased_frames),
      .dbg_overflow         (dbg_overflow),
      .dbg_level            (dbg_level)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input frame_word_t exp);
      logic [FRAME_Q_W-1:0] obs;
      logic [FRAME_Q_W-1:0] expv;
      obs  = {m_tlast, m_tkeep, m_tdata};
      expv = exp;
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic frame_word_t mk(input logic [63:0] seed, input logic [63:0] keep,
                                      input logic last);
      frame_word_t w;
      w.data = {8{seed}};
      w.keep = keep;
      w.last = last;
      return w;
   endfunction

   task automatic wr(input frame_word_t w, input logic confirm);
      frame_q_din     = w;
      frame_q_write   = 1'b1;
      frame_q_confirm = confirm;
      cyc();
      frame_q_write   = 1'b0;
      frame_q_confirm = 1'b0;
   endtask

   // Drain expq; every valid cycle (stalled or not) must show expq[0]
   task automatic drain(input string tag, input int budget, input logic toggle);
      logic [3:0] pat;
      int n;
      pat = 4'b1001;
      n = 0;
      while (expq.size() > 0 && n < budget) begin
         m_tready = toggle ? pat[n % 4] : 1'b1;
         if (m_tvalid) begin
            chk_word(tag, expq[0]);
            if (m_tready) void'(expq.pop_front());
         end
         cyc();
         n++;
      end
      m_tready = 1'b1;
      chk({tag, "_left"}, 64'(expq.size()), 64'd0);
      expq.delete();
   endtask

   initial begin
      rst = 1'b1;
      frame_q_write = 1'b0; frame_q_confirm = 1'b0; frame_q_erase = 1'b0;
      frame_q_din = '0;
      m_tready = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();

      // Reset state
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_full",   64'(frame_q_full), 64'd0);
      chk("rst_level",  64'(dbg_level), 64'd0);
      chk("rst_tdata",  m_tdata[63:0], 64'd0);
      chk("rst_commit", 64'(dbg_committed_frames), 64'd0);

      // 1: single-beat frame, 2-cycle latency
      wr(mk(64'hA1A1_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1), 1'b1);
      chk("t1_tvalid_e0", 64'(m_tvalid), 64'd0);
      chk("t1_level_e0",  64'(dbg_level), 64'd1);
      cyc();
      chk("t1_tvalid_e1", 64'(m_tvalid), 64'd0);
      cyc();
      chk("t1_tvalid_e2", 64'(m_tvalid), 64'd1);
      chk_word("t1_word", mk(64'hA1A1_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
      chk("t1_level", 64'(dbg_level), 64'd0);
      chk("t1_commit", 64'(dbg_committed_frames), 64'd1);
      cyc();
      chk("t1_tvalid_done", 64'(m_tvalid), 64'd0);

      // 2: erase rollback
      wr(mk(64'hB0, 64'hFF, 1'b0), 1'b0);
      wr(mk(64'hB1, 64'hFF, 1'b0), 1'b0);
      wr(mk(64'hB2, 64'hFF, 1'b1), 1'b0);
      chk("t2_level_open", 64'(dbg_level), 64'd3);
      frame_q_erase = 1'b1;
      cyc();
      frame_q_erase = 1'b0;
      chk("t2_level_erased", 64'(dbg_level), 64'd0);
      chk("t2_erased", 64'(dbg_erased_frames), 64'd1);
      chk("t2_no_output", 64'(m_tvalid), 64'd0);
      frame_q_erase = 1'b1;   // no open frame: no-op
      cyc();
      frame_q_erase = 1'b0;
      chk("t2_erase_noop", 64'(dbg_erased_frames), 64'd1);
      wr(mk(64'hC0, 64'h0F, 1'b0), 1'b0);
      wr(mk(64'hC1, 64'h03, 1'b1), 1'b1);
      expq.push_back(mk(64'hC0, 64'h0F, 1'b0));
      expq.push_back(mk(64'hC1, 64'h03, 1'b1));
      drain("t2_word", 20, 1'b0);
      chk("t2_tvalid_done", 64'(m_tvalid), 64'd0);
      chk("t2_commit", 64'(dbg_committed_frames), 64'd2);

      // 3: full boundary with output stalled
      m_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("t3_not_full", 64'(frame_q_full), 64'd0);
         wr(mk(64'hD00 + 64'(i), 64'hFFFF_0000_0000_0000 + 64'(i), (i == 7)), (i == 7));
      end
      chk("t3_full", 64'(frame_q_full), 64'd1);
      chk("t3_level8", 64'(dbg_level), 64'd8);
      chk("t3_ovf_pre", 64'(dbg_overflow), 64'd0);
      wr(mk(64'hDEAD, 64'h1, 1'b1), 1'b0);   // ignored, read issues this edge
      chk("t3_ovf", 64'(dbg_overflow), 64'd1);
      chk("t3_full_drop", 64'(frame_q_full), 64'd0);
      chk("t3_level7", 64'(dbg_level), 64'd7);
      for (int i = 0; i < 8; i++)
         expq.push_back(mk(64'hD00 + 64'(i), 64'hFFFF_0000_0000_0000 + 64'(i), (i == 7)));
      drain("t3_word", 40, 1'b0);
      chk("t3_level_done", 64'(dbg_level), 64'd0);
      chk("t3_tvalid_done", 64'(m_tvalid), 64'd0);
      chk("t3_commit", 64'(dbg_committed_frames), 64'd3);

      // 4: backpressure 1,0,0,1 pattern
      m_tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr(mk(64'hE0 + 64'(i), 64'(8'hF0 + i), (i == 3)), (i == 3));
         expq.push_back(mk(64'hE0 + 64'(i), 64'(8'hF0 + i), (i == 3)));
      end
      drain("t4_word", 40, 1'b1);
      chk("t4_tvalid_done", 64'(m_tvalid), 64'd0);
      chk("t4_level_done", 64'(dbg_level), 64'd0);

      // 5: reset with committed output pending and an open frame
      m_tready = 1'b0;
      wr(mk(64'hF00D, 64'h7, 1'b1), 1'b1);
      wr(mk(64'hF1, 64'h7, 1'b0), 1'b0);
      wr(mk(64'hF2, 64'h7, 1'b0), 1'b0);
      chk("t5_pre_tvalid", 64'(m_tvalid), 64'd1);
      chk("t5_pre_level", 64'(dbg_level), 64'd2);
      rst = 1'b1;
      #1;
      chk("t5_rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("t5_rst_level",  64'(dbg_level), 64'd0);
      chk("t5_rst_tdata",  m_tdata[63:0], 64'd0);
      chk("t5_rst_ovf",    64'(dbg_overflow), 64'd0);
      chk("t5_rst_commit", 64'(dbg_committed_frames), 64'd0);
      chk("t5_rst_erased", 64'(dbg_erased_frames), 64'd0);
      cyc();
      rst = 1'b0;
      m_tready = 1'b1;
      cyc();
      wr(mk(64'h5A0, 64'hFFFF, 1'b0), 1'b0);
      wr(mk(64'h5A1, 64'h00FF, 1'b1), 1'b1);
      expq.push_back(mk(64'h5A0, 64'hFFFF, 1'b0));
      expq.push_back(mk(64'h5A1, 64'h00FF, 1'b1));
      drain("t5_word", 20, 1'b0);
      chk("t5_commit", 64'(dbg_committed_frames), 64'd1);

      // 6: 16 back-to-back single-word frames, no bubbles
      cyc();
      m_tready = 1'b1;
      for (int k = 0; k < 21; k++) begin
         if (k < 16) begin
            frame_q_din     = mk(64'h6000 + 64'(k), 64'(k + 1), 1'b1);
            frame_q_write   = 1'b1;
            frame_q_confirm = 1'b1;
         end else begin
            frame_q_write   = 1'b0;
            frame_q_confirm = 1'b0;
         end
         if (k >= 3 && k < 19) begin
            chk("t6_tvalid_on", 64'(m_tvalid), 64'd1);
            chk_word("t6_word", mk(64'h6000 + 64'(k - 3), 64'(k - 2), 1'b1));
         end else begin
            chk("t6_tvalid_off", 64'(m_tvalid), 64'd0);
         end
         cyc();
      end
      chk("t6_commit", 64'(dbg_committed_frames), 64'd17);
      chk("t6_level", 64'(dbg_level), 64'd0);
      chk("t6_ovf", 64'(dbg_overflow), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
